jzjpcc_regfile_sb: RTL and testbench

- Parametrised integer register file with an integrated pending-write scoreboard for the pipelined core.
- NUM_READ combinational read ports, one synchronous write port, register 0 hardwired to zero.
- Per-register busy bits: set at issue, cleared at writeback, cleared in bulk on pipeline flush.
- Sits between decode (reads, issue marking) and writeback (write port); hazard logic consumes the busy outputs.

---
 rtl/jzjpcc_regfile_sb_if.sv | 37 +++
 rtl/jzjpcc_regfile_sb.sv | 86 ++++++++
 tb/tb_jzjpcc_regfile_sb.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jzjpcc_regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : jzjpcc_regfile_sb_if
// Brief    : Decode/writeback bus of the register file with pending-write
//            scoreboard. master = pipeline side, slave = register file.
// Revision : 1.0 - initial release
// ============================================================================
interface jzjpcc_regfile_sb_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_READ = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_READ*ADDR_W-1:0] rsAddr;
    logic [NUM_READ*XLEN-1:0]   rs;
    logic [NUM_READ-1:0]        rsBusy;
    logic [ADDR_W-1:0]          rdAddr;
    logic [XLEN-1:0]            rd;
    logic                       rdWriteEn;
    logic [ADDR_W-1:0]          issueAddr;
    logic                       issueEn;
    logic                       flush;
    logic                       anyBusy;
    logic [ADDR_W:0]            busyCount;

    modport master (
        output rsAddr, rdAddr, rd, rdWriteEn, issueAddr, issueEn, flush,
        input  rs, rsBusy, anyBusy, busyCount
    );

    modport slave (
        input  rsAddr, rdAddr, rd, rdWriteEn, issueAddr, issueEn, flush,
        output rs, rsBusy, anyBusy, busyCount
    );
endinterface
`default_nettype wire

// File: rtl/jzjpcc_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : jzjpcc_regfile_sb
// Brief    : Integer register file (x0 hardwired to zero) with per-register
//            pending-write busy bits. Optional write-through forwarding on the
//            read ports when JZJPCC_REGFILE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module jzjpcc_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_READ = 2
) (
    input  wire logic          clock,
    input  wire logic          not_reset,
    jzjpcc_regfile_sb_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [XLEN-1:0]     w_data [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic [ADDR_W:0]     w_count;

    assign w_data[0] = '0;
    assign w_busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic [XLEN-1:0] r_data;
        logic            r_busy;
        logic            w_wr_hit;
        logic            w_iss_hit;

        assign w_wr_hit  = bus.rdWriteEn && (bus.rdAddr == ADDR_W'(r));
        assign w_iss_hit = bus.issueEn && (bus.issueAddr == ADDR_W'(r));

        always_ff @(posedge clock or negedge not_reset) begin
            if (!not_reset) begin
                r_data <= '0;
                r_busy <= 1'b0;
            end else begin
                if (w_wr_hit)
                    r_data <= bus.rd;
                // Issue outranks writeback: the newer instruction owns the register.
                if (bus.flush)
                    r_busy <= 1'b0;
                else if (w_iss_hit)
                    r_busy <= 1'b1;
                else if (w_wr_hit)
                    r_busy <= 1'b0;
            end
        end

        assign w_data[r] = r_data;
        assign w_busy[r] = r_busy;
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_count = w_count + {{ADDR_W{1'b0}}, w_busy[i]};
    end

    assign bus.busyCount = w_count;
    assign bus.anyBusy   = |w_busy;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;

        assign w_addr = bus.rsAddr[i*ADDR_W +: ADDR_W];

`ifdef JZJPCC_REGFILE_BYPASS_EN
        logic w_fwd;

        // Gated by reset so the read ports stay quiet while held in reset.
        assign w_fwd = not_reset && bus.rdWriteEn && (bus.rdAddr == w_addr) &&
                       (w_addr != '0);
        assign bus.rs[i*XLEN +: XLEN] = w_fwd ? bus.rd : w_data[w_addr];
        assign bus.rsBusy[i]          = w_fwd ? (bus.issueEn && (bus.issueAddr == w_addr))
                                              : w_busy[w_addr];
`else
        assign bus.rs[i*XLEN +: XLEN] = w_data[w_addr];
        assign bus.rsBusy[i]          = w_busy[w_addr];
`endif
    end
endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_jzjpcc_regfile_sb
// Brief    : Directed self-checking bench for jzjpcc_regfile_sb (default and
//            64-bit / 16-register / 3-port configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jzjpcc_regfile_sb;
    logic clock     = 1'b0;
    logic not_reset = 1'b0;
    int   total     = 0;
    int   bad       = 0;

    jzjpcc_regfile_sb_if #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2)) bus0 ();
    jzjpcc_regfile_sb_if #(.XLEN(64), .NUM_REGS(16), .NUM_READ(3)) bus1 ();

    jzjpcc_regfile_sb #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2)) dut0 (
        .clock     (clock),
        .not_reset (not_reset),
        .bus       (bus0)
    );

    jzjpcc_regfile_sb #(.XLEN(64), .NUM_REGS(16), .NUM_READ(3)) dut1 (
        .clock     (clock),
        .not_reset (not_reset),
        .bus       (bus1)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle0;
        bus0.rdAddr = '0; bus0.rd = '0; bus0.rdWriteEn = 1'b0;
        bus0.issueAddr = '0; bus0.issueEn = 1'b0; bus0.flush = 1'b0;
    endtask

    task automatic idle1;
        bus1.rdAddr = '0; bus1.rd = '0; bus1.rdWriteEn = 1'b0;
        bus1.issueAddr = '0; bus1.issueEn = 1'b0; bus1.flush = 1'b0;
    endtask

    task automatic test_reset;
        not_reset = 1'b1;
        tick;
        bus0.rdWriteEn = 1'b1; bus0.rdAddr = 5'd4; bus0.rd = 32'h4444_4444;
        bus0.issueEn = 1'b1; bus0.issueAddr = 5'd6;
        tick;
        idle0;
        bus0.rsAddr = {5'd6, 5'd4};
        #1;
        total++;
        if (bus0.rs !== {32'h0, 32'h4444_4444}) begin
            bad++; $display("FAIL pre_reset_rs: got %h expected %h", bus0.rs, {32'h0, 32'h4444_4444});
        end
        total++;
        if (bus0.busyCount !== 6'd1) begin
            bad++; $display("FAIL pre_reset_count: got %0d expected 1", bus0.busyCount);
        end
        #1;
        not_reset = 1'b0;
        #1;
        total++;
        if (bus0.anyBusy !== 1'b0 || bus0.busyCount !== 6'd0) begin
            bad++; $display("FAIL reset_busy: got any=%b count=%0d expected 0/0", bus0.anyBusy, bus0.busyCount);
        end
        for (int a = 0; a < 32; a++) begin
            bus0.rsAddr = {5'(31 - a), 5'(a)};
            #1;
            total++;
            if (bus0.rs !== 64'h0 || bus0.rsBusy !== 2'b00) begin
                bad++; $display("FAIL reset_read a=%0d: got rs=%h busy=%b expected 0/00", a, bus0.rs, bus0.rsBusy);
            end
        end
        tick;
        not_reset = 1'b1;
    endtask

    task automatic test_x0;
        bus0.rdWriteEn = 1'b1; bus0.rdAddr = 5'd0; bus0.rd = 32'hDEAD_BEEF;
        bus0.issueEn = 1'b1; bus0.issueAddr = 5'd0;
        tick;
        idle0;
        bus0.rsAddr = {5'd0, 5'd0};
        #1;
        total++;
        if (bus0.rs !== 64'h0 || bus0.rsBusy !== 2'b00 || bus0.busyCount !== 6'd0) begin
            bad++; $display("FAIL x0: got rs=%h busy=%b count=%0d expected 0/00/0", bus0.rs, bus0.rsBusy, bus0.busyCount);
        end
    endtask

    task automatic test_issue_wb;
        bus0.issueEn = 1'b1; bus0.issueAddr = 5'd5;
        tick;
        idle0;
        bus0.rsAddr = {5'd0, 5'd5};
        #1;
        total++;
        if (bus0.rsBusy[0] !== 1'b1 || bus0.busyCount !== 6'd1 || bus0.anyBusy !== 1'b1) begin
            bad++; $display("FAIL issue_r5: got busy=%b count=%0d any=%b expected 1/1/1", bus0.rsBusy[0], bus0.busyCount, bus0.anyBusy);
        end
        tick;
        bus0.rdWriteEn = 1'b1; bus0.rdAddr = 5'd5; bus0.rd = 32'h1234_5678;
        #1;
        total++;
`ifdef JZJPCC_REGFILE_BYPASS_EN
        if (bus0.rs[31:0] !== 32'h1234_5678 || bus0.rsBusy[0] !== 1'b0) begin
            bad++; $display("FAIL wb_r5_same_cycle: got rs=%h busy=%b expected 12345678/0", bus0.rs[31:0], bus0.rsBusy[0]);
        end
`else
        if (bus0.rs[31:0] !== 32'h0 || bus0.rsBusy[0] !== 1'b1) begin
            bad++; $display("FAIL wb_r5_same_cycle: got rs=%h busy=%b expected 00000000/1", bus0.rs[31:0], bus0.rsBusy[0]);
        end
`endif
        tick;
        idle0;
        #1;
        total++;
        if (bus0.rs[31:0] !== 32'h1234_5678 || bus0.rsBusy[0] !== 1'b0 || bus0.busyCount !== 6'd0) begin
            bad++; $display("FAIL wb_r5: got rs=%h busy=%b count=%0d expected 12345678/0/0", bus0.rs[31:0], bus0.rsBusy[0], bus0.busyCount);
        end
    endtask

    task automatic test_issue_wb_same_and_flush;
        bus0.rdWriteEn = 1'b1; bus0.rdAddr = 5'd7; bus0.rd = 32'h7777_0007;
        bus0.issueEn = 1'b1; bus0.issueAddr = 5'd7;
        tick;
        idle0;
        bus0.rsAddr = {5'd7, 5'd0};
        #1;
        total++;
        if (bus0.rs[63:32] !== 32'h7777_0007 || bus0.rsBusy[1] !== 1'b1 || bus0.busyCount !== 6'd1) begin
            bad++; $display("FAIL issue_wb_r7: got rs=%h busy=%b count=%0d expected 77770007/1/1", bus0.rs[63:32], bus0.rsBusy[1], bus0.busyCount);
        end
        bus0.issueEn = 1'b1; bus0.issueAddr = 5'd1;
        tick;
        bus0.issueAddr = 5'd2;
        tick;
        idle0;
        #1;
        total++;
        if (bus0.busyCount !== 6'd3) begin
            bad++; $display("FAIL pre_flush_count: got %0d expected 3", bus0.busyCount);
        end
        bus0.flush = 1'b1;
        bus0.issueEn = 1'b1; bus0.issueAddr = 5'd9;
        bus0.rdWriteEn = 1'b1; bus0.rdAddr = 5'd2; bus0.rd = 32'h2222_2222;
        tick;
        idle0;
        bus0.rsAddr = {5'd2, 5'd9};
        #1;
        total++;
        if (bus0.busyCount !== 6'd0 || bus0.anyBusy !== 1'b0 || bus0.rsBusy !== 2'b00) begin
            bad++; $display("FAIL flush: got count=%0d any=%b busy=%b expected 0/0/00", bus0.busyCount, bus0.anyBusy, bus0.rsBusy);
        end
        total++;
        if (bus0.rs[63:32] !== 32'h2222_2222) begin
            bad++; $display("FAIL flush_write: got %h expected 22222222", bus0.rs[63:32]);
        end
    endtask

    task automatic test_reissue_and_multi_read;
        bus0.issueEn = 1'b1; bus0.issueAddr = 5'd11;
        tick;
        tick;
        idle0;
        bus0.rdWriteEn = 1'b1; bus0.rdAddr = 5'd11; bus0.rd = 32'h0000_00BB;
        tick;
        idle0;
        bus0.rsAddr = {5'd0, 5'd11};
        #1;
        total++;
        if (bus0.rs[31:0] !== 32'hBB || bus0.rsBusy[0] !== 1'b0 || bus0.busyCount !== 6'd0) begin
            bad++; $display("FAIL reissue_r11: got rs=%h busy=%b count=%0d expected bb/0/0", bus0.rs[31:0], bus0.rsBusy[0], bus0.busyCount);
        end
        bus0.rdWriteEn = 1'b1; bus0.rdAddr = 5'd10; bus0.rd = 32'h0000_00AA;
        tick;
        idle0;
        bus0.rsAddr = {5'd10, 5'd10};
        #1;
        total++;
        if (bus0.rs !== {32'hAA, 32'hAA} || bus0.rsBusy !== 2'b00) begin
            bad++; $display("FAIL multi_read_r10: got rs=%h busy=%b expected 000000aa000000aa/00", bus0.rs, bus0.rsBusy);
        end
    endtask

    task automatic test_bypass;
        bus0.rdWriteEn = 1'b1; bus0.rdAddr = 5'd3; bus0.rd = 32'h1111_1111;
        tick;
        bus0.rsAddr = {5'd0, 5'd3};
        bus0.rd = 32'hA5A5_A5A5;
        #1;
        total++;
`ifdef JZJPCC_REGFILE_BYPASS_EN
        if (bus0.rs[31:0] !== 32'hA5A5_A5A5 || bus0.rsBusy[0] !== 1'b0) begin
            bad++; $display("FAIL bypass_r3: got rs=%h busy=%b expected a5a5a5a5/0", bus0.rs[31:0], bus0.rsBusy[0]);
        end
`else
        if (bus0.rs[31:0] !== 32'h1111_1111 || bus0.rsBusy[0] !== 1'b0) begin
            bad++; $display("FAIL bypass_r3: got rs=%h busy=%b expected 11111111/0", bus0.rs[31:0], bus0.rsBusy[0]);
        end
`endif
        tick;
        idle0;
        #1;
        total++;
        if (bus0.rs[31:0] !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL after_write_r3: got %h expected a5a5a5a5", bus0.rs[31:0]);
        end
        bus0.rdWriteEn = 1'b1; bus0.rdAddr = 5'd3; bus0.rd = 32'h5A5A_5A5A;
        bus0.issueEn = 1'b1; bus0.issueAddr = 5'd3;
        #1;
        total++;
`ifdef JZJPCC_REGFILE_BYPASS_EN
        if (bus0.rs[31:0] !== 32'h5A5A_5A5A || bus0.rsBusy[0] !== 1'b1) begin
            bad++; $display("FAIL bypass_issue_r3: got rs=%h busy=%b expected 5a5a5a5a/1", bus0.rs[31:0], bus0.rsBusy[0]);
        end
`else
        if (bus0.rs[31:0] !== 32'hA5A5_A5A5 || bus0.rsBusy[0] !== 1'b0) begin
            bad++; $display("FAIL bypass_issue_r3: got rs=%h busy=%b expected a5a5a5a5/0", bus0.rs[31:0], bus0.rsBusy[0]);
        end
`endif
        tick;
        idle0;
        #1;
        total++;
        if (bus0.rs[31:0] !== 32'h5A5A_5A5A || bus0.rsBusy[0] !== 1'b1) begin
            bad++; $display("FAIL issue_write_r3: got rs=%h busy=%b expected 5a5a5a5a/1", bus0.rs[31:0], bus0.rsBusy[0]);
        end
        bus0.rdWriteEn = 1'b1; bus0.rdAddr = 5'd3; bus0.rd = 32'h5A5A_5A5A;
        tick;
        idle0;
        #1;
        total++;
        if (bus0.rsBusy[0] !== 1'b0 || bus0.busyCount !== 6'd0) begin
            bad++; $display("FAIL clear_r3: got busy=%b count=%0d expected 0/0", bus0.rsBusy[0], bus0.busyCount);
        end
    endtask

    task automatic test_sweep;
        logic [63:0] model [16];
        int          a [3];
        logic [31:0] v;

        model[0] = '0;
        for (int i = 1; i < 16; i++) begin
            v = 32'(i) * 32'h0101_0101;
            model[i] = {v, ~v};
            bus1.rdWriteEn = 1'b1; bus1.rdAddr = 4'(i); bus1.rd = model[i];
            tick;
        end
        idle1;
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 3; k++)
                a[k] = int'($urandom_range(15, 0));
            bus1.rsAddr = {4'(a[2]), 4'(a[1]), 4'(a[0])};
            #1;
            for (int p = 0; p < 3; p++) begin
                total++;
                if (bus1.rs[p*64 +: 64] !== model[a[p]] || bus1.rsBusy[p] !== 1'b0) begin
                    bad++; $display("FAIL sweep port%0d addr=%0d: got %h busy=%b expected %h/0", p, a[p], bus1.rs[p*64 +: 64], bus1.rsBusy[p], model[a[p]]);
                end
            end
            tick;
        end
        for (int i = 0; i < 16; i++) begin
            bus1.issueEn = 1'b1; bus1.issueAddr = 4'(i);
            tick;
        end
        idle1;
        #1;
        total++;
        if (bus1.busyCount !== 5'd15 || bus1.anyBusy !== 1'b1) begin
            bad++; $display("FAIL sweep_all_busy: got count=%0d any=%b expected 15/1", bus1.busyCount, bus1.anyBusy);
        end
        bus1.flush = 1'b1;
        tick;
        idle1;
        #1;
        total++;
        if (bus1.busyCount !== 5'd0 || bus1.anyBusy !== 1'b0) begin
            bad++; $display("FAIL sweep_flush: got count=%0d any=%b expected 0/0", bus1.busyCount, bus1.anyBusy);
        end
    endtask

    initial begin
        idle0;
        idle1;
        bus0.rsAddr = '0;
        bus1.rsAddr = '0;
        #12;
        test_reset;
        test_x0;
        test_issue_wb;
        test_issue_wb_same_and_flush;
        test_reissue_and_multi_read;
        test_bypass;
        test_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
`default_nettype wire
